// File: rtl/sprite_pkg.sv
// Screen geometry, sprite payload and paddle enums shared by the paddle datapath.
package sprite_pkg;

  localparam int unsigned SCREEN_H_RES  = 640;
  localparam int unsigned SCREEN_V_RES  = 480;
  localparam int unsigned SCREEN_BORDER = 8;
  localparam int unsigned PADDLE_WIDTH  = 10;
  localparam int unsigned PADDLE_HEIGHT = 50;
  localparam int unsigned X_POS_W       = 10;
  localparam int unsigned Y_POS_W       = 10;

  localparam int unsigned PADDLE_CENTER = PADDLE_HEIGHT / 2;
  localparam int unsigned V_CENTER      = (SCREEN_V_RES - PADDLE_HEIGHT) / 2;
  localparam int unsigned UP_LIMIT      = SCREEN_BORDER;
  localparam int unsigned DOWN_LIMIT    = SCREEN_V_RES - SCREEN_BORDER - PADDLE_HEIGHT;

  typedef struct packed {
    logic [X_POS_W-1:0] x_pos;
    logic [Y_POS_W-1:0] y_pos;
    logic [X_POS_W-1:0] right;
    logic [Y_POS_W-1:0] bottom;
  } sprite_t;

  typedef enum logic [1:0] {HOLD = 2'd0, UP = 2'd1, DOWN = 2'd2} paddle_dir_t;

  typedef enum logic {MODE_MANUAL = 1'b0, MODE_AI = 1'b1} paddle_mode_t;

endpackage

// File: rtl/paddle_axis.sv
// One paddle channel: direction FSM, cycles-per-pixel step counter and y clamp.
module paddle_axis
  import sprite_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEADZONE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               restart_i,
  input  logic               freeze_i,
  input  logic               mode_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic [CNT_W-1:0]   speed_i,
  input  logic [Y_POS_W-1:0] target_y_i,
  output logic [Y_POS_W-1:0] y_pos_o,
  output logic               at_limit_o
);

  localparam int unsigned CMP_W = Y_POS_W + 1;

  paddle_dir_t        state_q, state_d;
  paddle_dir_t        req_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [Y_POS_W-1:0] y_q, y_d;
  logic [CMP_W-1:0]   centre_c, tgt_c, dz_c;
  logic               wrap_c;

  // Requested direction; AI compare is widened so centre-DEADZONE cannot underflow.
  always_comb begin
    centre_c = CMP_W'(y_q) + CMP_W'(PADDLE_CENTER);
    tgt_c    = CMP_W'(target_y_i);
    dz_c     = CMP_W'(DEADZONE);
    req_c    = HOLD;
    if (paddle_mode_t'(mode_i) == MODE_AI) begin
      if ((tgt_c + dz_c) < centre_c)      req_c = UP;
      else if (tgt_c > (centre_c + dz_c)) req_c = DOWN;
    end else begin
      if (up_i && !down_i)      req_c = UP;
      else if (down_i && !up_i) req_c = DOWN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      y_q     <= Y_POS_W'(V_CENTER);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (restart_i)              state_d = HOLD;
    else if (!freeze_i)         state_d = req_c;
  end

  // Counter and position update; speed 0 parks the counter so no step ever fires.
  always_comb begin
    cnt_d  = cnt_q;
    y_d    = y_q;
    wrap_c = (speed_i != '0) && (cnt_q == CNT_W'(speed_i - CNT_W'(1)));
    if (restart_i) begin
      cnt_d = '0;
      y_d   = Y_POS_W'(V_CENTER);
    end else if (!freeze_i) begin
      if (req_c != state_q) begin
        cnt_d = '0;
      end else if (state_q != HOLD) begin
        if (speed_i == '0) begin
          cnt_d = '0;
        end else if (wrap_c) begin
          cnt_d = '0;
          if (state_q == UP && y_q > Y_POS_W'(UP_LIMIT))
            y_d = y_q - Y_POS_W'(1);
          else if (state_q == DOWN && y_q < Y_POS_W'(DOWN_LIMIT))
            y_d = y_q + Y_POS_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign y_pos_o    = y_q;
  assign at_limit_o = (y_q == Y_POS_W'(UP_LIMIT)) || (y_q == Y_POS_W'(DOWN_LIMIT));

endmodule

// File: rtl/paddle_array_ctrl.sv
// Array of independent paddle channels with reset synchroniser and sprite output packing.
module paddle_array_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned N_PADDLES = 2,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DEADZONE  = 4,
  parameter logic [N_PADDLES-1:0][X_POS_W-1:0] X_POS =
    {X_POS_W'(SCREEN_BORDER), X_POS_W'(SCREEN_H_RES - SCREEN_BORDER - PADDLE_WIDTH)}
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            restart_i,
  input  logic                            freeze_i,
  input  logic [N_PADDLES-1:0]            mode_i,
  input  logic [N_PADDLES-1:0]            up_i,
  input  logic [N_PADDLES-1:0]            down_i,
  input  logic [N_PADDLES-1:0][CNT_W-1:0] speed_i,
  input  logic [Y_POS_W-1:0]              target_y_i,
  output sprite_t [N_PADDLES-1:0]         paddles_o,
  output logic [N_PADDLES-1:0]            at_limit_o
);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_sync;

  // Asynchronous assert, two-flop synchronised release.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_n_sync = rst_sync_q[1];

  for (genvar n = 0; n < N_PADDLES; n++) begin : g_ch
    logic [Y_POS_W-1:0] y_pos;

    paddle_axis #(
      .CNT_W    (CNT_W),
      .DEADZONE (DEADZONE)
    ) u_axis (
      .clk        (clk),
      .rst_n      (rst_n_sync),
      .restart_i  (restart_i),
      .freeze_i   (freeze_i),
      .mode_i     (mode_i[n]),
      .up_i       (up_i[n]),
      .down_i     (down_i[n]),
      .speed_i    (speed_i[n]),
      .target_y_i (target_y_i),
      .y_pos_o    (y_pos),
      .at_limit_o (at_limit_o[n])
    );

    always_comb begin
      paddles_o[n].x_pos  = X_POS[n];
      paddles_o[n].right  = X_POS[n] + X_POS_W'(PADDLE_WIDTH - 1);
      paddles_o[n].y_pos  = y_pos;
      paddles_o[n].bottom = y_pos + Y_POS_W'(PADDLE_HEIGHT - 1);
    end
  end

endmodule

// File: tb/tb_paddle_array_ctrl.sv
// Directed bench for paddle_array_ctrl: timing, clamp, AI tracking, freeze/restart, reset.
module tb_paddle_array_ctrl;
  import sprite_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned CW = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  restart_i, freeze_i;
  logic [NP-1:0]         mode_i, up_i, down_i;
  logic [NP-1:0][CW-1:0] speed_i;
  logic [Y_POS_W-1:0]    target_y_i;
  sprite_t [NP-1:0]      paddles_o;
  logic [NP-1:0]         at_limit_o;

  int checks = 0;
  int errors = 0;

  paddle_array_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart_i  (restart_i),
    .freeze_i   (freeze_i),
    .mode_i     (mode_i),
    .up_i       (up_i),
    .down_i     (down_i),
    .speed_i    (speed_i),
    .target_y_i (target_y_i),
    .paddles_o  (paddles_o),
    .at_limit_o (at_limit_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_restart();
    restart_i = 1'b1;
    tick(1);
    restart_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; restart_i = 1'b0; freeze_i = 1'b0;
    mode_i = '0; up_i = '0; down_i = '0; target_y_i = '0;
    speed_i[0] = 16'd4; speed_i[1] = 16'd4;
    tick(2);
    chk("rst_y0",      32'(paddles_o[0].y_pos),  32'd215);
    chk("rst_y1",      32'(paddles_o[1].y_pos),  32'd215);
    chk("rst_limit",   32'(at_limit_o),          32'd0);
    chk("rst_x0",      32'(paddles_o[0].x_pos),  32'd622);
    chk("rst_right0",  32'(paddles_o[0].right),  32'd631);
    chk("rst_x1",      32'(paddles_o[1].x_pos),  32'd8);
    chk("rst_right1",  32'(paddles_o[1].right),  32'd17);
    chk("rst_bottom0", 32'(paddles_o[0].bottom), 32'd264);
    rst_n = 1'b1;
    tick(3);

    // Manual up, speed 4: steps at edges 5, 9, 13
    up_i[0] = 1'b1;
    tick(4); chk("man_e4",  32'(paddles_o[0].y_pos), 32'd215);
    tick(1); chk("man_e5",  32'(paddles_o[0].y_pos), 32'd214);
    tick(3); chk("man_e8",  32'(paddles_o[0].y_pos), 32'd214);
    tick(1); chk("man_e9",  32'(paddles_o[0].y_pos), 32'd213);
    tick(4); chk("man_e13", 32'(paddles_o[0].y_pos), 32'd212);
    chk("man_bot", 32'(paddles_o[0].bottom), 32'd261);
    chk("man_y1",  32'(paddles_o[1].y_pos),  32'd215);
    up_i[0] = 1'b0;
    tick(10); chk("man_hold", 32'(paddles_o[0].y_pos), 32'd212);
    do_restart();
    chk("restart_y0", 32'(paddles_o[0].y_pos), 32'd215);

    // Freeze mid-count keeps the counter
    down_i[0] = 1'b1;
    tick(2);
    freeze_i = 1'b1;
    tick(10); chk("frz_held", 32'(paddles_o[0].y_pos), 32'd215);
    freeze_i = 1'b0;
    tick(1); chk("frz_c3",  32'(paddles_o[0].y_pos), 32'd215);
    tick(1); chk("frz_pre", 32'(paddles_o[0].y_pos), 32'd215);
    tick(1); chk("frz_step", 32'(paddles_o[0].y_pos), 32'd216);
    down_i[0] = 1'b0;
    freeze_i = 1'b1;
    do_restart();
    chk("rst_frz_y0", 32'(paddles_o[0].y_pos), 32'd215);
    freeze_i = 1'b0;

    // Both buttons on ch0, speed 0 on ch1
    up_i[0] = 1'b1; down_i[0] = 1'b1; speed_i[0] = 16'd1;
    down_i[1] = 1'b1; speed_i[1] = 16'd0;
    tick(10);
    chk("ind_y0", 32'(paddles_o[0].y_pos), 32'd215);
    chk("ind_y1", 32'(paddles_o[1].y_pos), 32'd215);
    speed_i[1] = 16'd1;
    tick(1); chk("ind_s1a", 32'(paddles_o[1].y_pos), 32'd216);
    tick(1); chk("ind_s1b", 32'(paddles_o[1].y_pos), 32'd217);
    chk("ind_y0b", 32'(paddles_o[0].y_pos), 32'd215);

    // Clamp at DOWN_LIMIT with speed 1
    do_restart();
    tick(207);
    chk("clamp_421", 32'(paddles_o[1].y_pos), 32'd421);
    chk("clamp_lim0", 32'(at_limit_o[1]), 32'd0);
    tick(1);
    chk("clamp_422", 32'(paddles_o[1].y_pos), 32'd422);
    chk("clamp_lim1", 32'(at_limit_o[1]), 32'd1);
    tick(5);
    chk("clamp_stay", 32'(paddles_o[1].y_pos), 32'd422);
    chk("clamp_lim2", 32'(at_limit_o[1]), 32'd1);
    chk("clamp_y0",   32'(paddles_o[0].y_pos), 32'd215);

    // AI tracking towards 100, then reversal
    down_i[1] = 1'b0; up_i[0] = 1'b0; down_i[0] = 1'b0;
    mode_i[0] = 1'b1; speed_i[0] = 16'd2; target_y_i = 10'd100;
    do_restart();
    tick(272); chk("ai_80", 32'(paddles_o[0].y_pos), 32'd80);
    tick(1);   chk("ai_79", 32'(paddles_o[0].y_pos), 32'd79);
    tick(10);  chk("ai_hold", 32'(paddles_o[0].y_pos), 32'd79);
    chk("ai_y1", 32'(paddles_o[1].y_pos), 32'd215);
    target_y_i = 10'd240;
    tick(2); chk("ai_rev_a", 32'(paddles_o[0].y_pos), 32'd79);
    tick(2); chk("ai_rev_b", 32'(paddles_o[0].y_pos), 32'd80);
    target_y_i = 10'd100;
    tick(2); chk("ai_clr_a", 32'(paddles_o[0].y_pos), 32'd80);
    tick(1); chk("ai_clr_b", 32'(paddles_o[0].y_pos), 32'd79);

    // Reset asserted mid-motion
    mode_i[0] = 1'b0; down_i[0] = 1'b1; speed_i[0] = 16'd1;
    do_restart();
    tick(5); chk("mid_219", 32'(paddles_o[0].y_pos), 32'd219);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_y0",  32'(paddles_o[0].y_pos), 32'd215);
    chk("mid_rst_y1",  32'(paddles_o[1].y_pos), 32'd215);
    chk("mid_rst_lim", 32'(at_limit_o),         32'd0);
    chk("mid_rst_r0",  32'(paddles_o[0].right), 32'd631);
    tick(2);
    rst_n = 1'b1;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/paddle_array_ctrl.md
PADDLE_ARRAY_CTRL -- requirements
Module: paddle_array_ctrl

Interface
REQ-001 SHALL have parameter N_PADDLES, default 2, number of independent paddle channels.
REQ-002 SHALL have parameter CNT_W, default 16, width of per-channel speed (cycles-per-pixel) value.
REQ-003 SHALL have parameter DEADZONE, default 4, AI tracking half-window in pixels.
REQ-004 SHALL have parameter logic [N_PADDLES-1:0][X_POS_W-1:0] X_POS, default {SCREEN_BORDER, SCREEN_H_RES-SCREEN_BORDER-PADDLE_WIDTH}, fixed left x per channel.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 restart_i  input  1  synchronous recentre of all channels.
REQ-008 freeze_i  input  1  hold all positions and counters (pause).
REQ-009 mode_i  input  N_PADDLES  per channel: 0 manual, 1 AI tracking.
REQ-010 up_i / down_i  input  N_PADDLES each  manual move commands.
REQ-011 speed_i  input  N_PADDLES x CNT_W  clock cycles per 1-pixel step.
REQ-012 target_y_i  input  Y_POS_W  shared AI target (ball centre y).
REQ-013 paddles_o  output  N_PADDLES x sprite_t  x_pos, y_pos, right, bottom per channel.
REQ-014 at_limit_o  output  N_PADDLES  high while y_pos equals UP_LIMIT or DOWN_LIMIT.

Function
REQ-015 Requested direction SHALL be: manual -- UP if up only, DOWN if down only, HOLD if both or neither; AI -- UP if target_y_i < centre-DEADZONE, DOWN if target_y_i > centre+DEADZONE, else HOLD, centre = y_pos+PADDLE_CENTER, compared in Y_POS_W+1 bits (no underflow).
REQ-016 Each channel SHALL hold a 3-state FSM {HOLD, UP, DOWN} and a step counter.
REQ-017 When requested direction differs from state, state SHALL take the request and counter SHALL clear to 0, no step that cycle.
REQ-018 When request equals state and state != HOLD, counter SHALL increment; at counter == speed_i-1 it SHALL return to 0 and y_pos SHALL move 1 pixel (UP: -1, DOWN: +1).
REQ-019 First step SHALL therefore occur on the (speed_i+1)th edge of a held command; subsequent steps every speed_i edges.
REQ-020 speed_i == 0 SHALL mean never step (counter held at 0); speed_i == 1 SHALL step every cycle after the entry cycle.
REQ-021 y_pos SHALL clamp to [UP_LIMIT, DOWN_LIMIT]; a blocked step SHALL leave y_pos unchanged and counter still wraps.
REQ-022 freeze_i high SHALL hold FSM state, counters and y_pos; restart_i SHALL override freeze_i.
REQ-023 restart_i high SHALL set every y_pos to V_CENTER, state HOLD, counter 0 on that edge.
REQ-024 Mode change mid-motion SHALL be handled by REQ-017 only (no special case).
REQ-025 paddles_o SHALL be derived from registered y_pos with zero added latency: x_pos = X_POS[n], right = x_pos+PADDLE_WIDTH-1, bottom = y_pos+PADDLE_HEIGHT-1.
REQ-026 Channels SHALL be fully independent; one channel's inputs SHALL not affect another's outputs.

Reset
REQ-027 On rst_n low every y_pos SHALL be V_CENTER, state HOLD, counter 0, at_limit_o 0, paddles_o x/right per REQ-025.
REQ-028 Reset assertion mid-step SHALL abort the step with no partial update; release SHALL be synchronised so first active edge behaves as REQ-017.

Structure
REQ-029 sprite_pkg SHALL gain paddle_dir_t enum {HOLD, UP, DOWN}, paddle_mode_t, UP_LIMIT = SCREEN_BORDER, and reuse DOWN_LIMIT, V_CENTER, PADDLE_CENTER, sprite_t.
REQ-030 One channel SHALL be a sub-module paddle_axis (FSM, counter, clamp), instantiated N_PADDLES times by generate.

Verification
REQ-031 Manual: speed=4, up held from y=215 -> y=214,213,212 at edges 5,9,13; release -> state HOLD, y holds.
REQ-032 Clamp: y=DOWN_LIMIT, down held, speed=1 -> y stays DOWN_LIMIT, at_limit_o=1 throughout.
REQ-033 AI: target_y=100, y=215, speed=2 -> y decreases until centre within 100+-4, then HOLD; target=240 reverses with counter cleared.
REQ-034 Freeze/restart: freeze mid-count 10 cycles -> no step, resumes with counter intact; restart with freeze high -> all y=V_CENTER next edge.
REQ-035 Independence/edge: ch0 up+down both high, ch1 down speed=0 -> both y unchanged; ch1 speed to 1 -> ch1 steps, ch0 unchanged.
REQ-036 Reset mid-motion: rst_n low during DOWN -> y=V_CENTER immediately, outputs per REQ-027.
